// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage RV32IM pipeline. It drives the
// write-enable and flush (bubble) inputs of the PC and of the IF/ID, ID/EX,
// EX/MEM and MEM/WB pipeline registers from the pipeline hazard sources. It
// also keeps a saturating count of cycles in which the PC was held.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   id_rs1/id_rs2    source registers of the instruction in ID
//   id_use_rs1/2     ID instruction actually reads rs1 / rs2
//   ex_write_addr    rd of the instruction in EX
//   ex_mem_read      EX instruction is a load
//   ex_is_muldiv     EX instruction is an M-extension op
//   ex_branch_taken  EX resolved a taken branch or jump
//   imem_busywait    instruction memory not ready
//   dmem_busywait    data memory not ready
//   md_done          mul/div result valid (single-cycle pulse)
//   cnt_clear        synchronous clear of the stall counter
//   *_en             pipeline register / PC capture enables
//   *_flush          load NOP / bubble into the pipeline register
//   md_start         start pulse to the mul/div unit
//   md_error         sticky mul/div timeout flag
//   stall_count      saturating count of cycles with pc_write_en low
//
// Event priority, highest first:
//   memory freeze > mul/div > branch flush > load-use
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int STALL_CNT_WIDTH = 16,
    parameter int MD_MAX_CYCLES   = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic                       id_use_rs1,
    input  logic                       id_use_rs2,
    input  logic [4:0]                 ex_write_addr,
    input  logic                       ex_mem_read,
    input  logic                       ex_is_muldiv,
    input  logic                       ex_branch_taken,
    input  logic                       imem_busywait,
    input  logic                       dmem_busywait,
    input  logic                       md_done,
    input  logic                       cnt_clear,
    output logic                       pc_write_en,
    output logic                       if_id_en,
    output logic                       id_ex_en,
    output logic                       ex_mem_en,
    output logic                       mem_wb_en,
    output logic                       if_id_flush,
    output logic                       id_ex_flush,
    output logic                       ex_mem_flush,
    output logic                       md_start,
    output logic                       md_error,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    // Wait counter only has to reach MD_MAX_CYCLES-1.
    localparam int MD_CNT_W = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_MAX_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and registered flags
    // ------------------------------------------------------------------
    state_t                     state_q,       state_d;
    logic [MD_CNT_W-1:0]        md_wait_cnt_q, md_wait_cnt_d;
    logic                       md_pend_q,     md_pend_d;
    logic                       md_error_q,    md_error_d;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // Control outputs before reset gating.
    logic pc_write_en_raw;
    logic if_id_en_raw;
    logic id_ex_en_raw;
    logic ex_mem_en_raw;
    logic mem_wb_en_raw;
    logic if_id_flush_raw;
    logic id_ex_flush_raw;
    logic ex_mem_flush_raw;
    logic md_start_raw;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic mem_freeze;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic md_timeout;

    assign mem_freeze = imem_busywait | dmem_busywait;

    // x0 is hard-wired zero, so a load "writing" x0 never creates a hazard.
    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_write_addr);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_write_addr);
    assign load_use = ex_mem_read && (ex_write_addr != 5'd0) && (rs1_hit || rs2_hit);

    assign md_timeout = (md_wait_cnt_q == MD_LAST);

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Free-running pipeline by default.
        pc_write_en_raw  = 1'b1;
        if_id_en_raw     = 1'b1;
        id_ex_en_raw     = 1'b1;
        ex_mem_en_raw    = 1'b1;
        mem_wb_en_raw    = 1'b1;
        if_id_flush_raw  = 1'b0;
        id_ex_flush_raw  = 1'b0;
        ex_mem_flush_raw = 1'b0;
        md_start_raw     = 1'b0;

        state_d       = state_q;
        md_wait_cnt_d = md_wait_cnt_q;
        md_pend_d     = md_pend_q;
        md_error_d    = md_error_q;

        if (mem_freeze) begin
            // Whole pipeline frozen; the FSM and wait counter are held too,
            // so a freeze never eats into the mul/div timeout budget.
            pc_write_en_raw = 1'b0;
            if_id_en_raw    = 1'b0;
            id_ex_en_raw    = 1'b0;
            ex_mem_en_raw   = 1'b0;
            mem_wb_en_raw   = 1'b0;
            // A done pulse seen while frozen would otherwise be lost.
            if ((state_q == ST_MD_BUSY) && md_done) begin
                md_pend_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_is_muldiv) begin
                        // Launch the unit, hold everything upstream of EX and
                        // push bubbles into EX/MEM while older work drains.
                        md_start_raw     = 1'b1;
                        pc_write_en_raw  = 1'b0;
                        if_id_en_raw     = 1'b0;
                        id_ex_en_raw     = 1'b0;
                        ex_mem_flush_raw = 1'b1;
                        state_d          = ST_MD_BUSY;
                        md_wait_cnt_d    = '0;
                        md_pend_d        = 1'b0;
                    end else if (ex_branch_taken) begin
                        // Squash the two wrong-path instructions.
                        if_id_flush_raw = 1'b1;
                        id_ex_flush_raw = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID one cycle; EX gets a bubble.
                        pc_write_en_raw = 1'b0;
                        if_id_en_raw    = 1'b0;
                        id_ex_flush_raw = 1'b1;
                    end
                end

                ST_MD_BUSY: begin
                    if (md_done || md_pend_q) begin
                        // Result ready: defaults let EX/MEM capture it.
                        md_pend_d = 1'b0;
                        state_d   = ST_RUN;
                    end else if (md_timeout) begin
                        // Give up: flag it and let the pipeline move on as if
                        // the result had arrived.
                        md_error_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        pc_write_en_raw  = 1'b0;
                        if_id_en_raw     = 1'b0;
                        id_ex_en_raw     = 1'b0;
                        ex_mem_flush_raw = 1'b1;
                        md_wait_cnt_d    = md_wait_cnt_q + MD_CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter; clear wins over increment.
    // ------------------------------------------------------------------
    always_comb begin
        stall_count_d = stall_count_q;
        if (cnt_clear) begin
            stall_count_d = '0;
        end else if (!pc_write_en_raw && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            md_wait_cnt_q <= '0;
            md_pend_q     <= 1'b0;
            md_error_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_wait_cnt_q <= md_wait_cnt_d;
            md_pend_q     <= md_pend_d;
            md_error_q    <= md_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: controls are forced inactive while reset is asserted so the
    // pipeline registers stay put regardless of the hazard inputs.
    // ------------------------------------------------------------------
    assign pc_write_en  = pc_write_en_raw  & reset;
    assign if_id_en     = if_id_en_raw     & reset;
    assign id_ex_en     = id_ex_en_raw     & reset;
    assign ex_mem_en    = ex_mem_en_raw    & reset;
    assign mem_wb_en    = mem_wb_en_raw    & reset;
    assign if_id_flush  = if_id_flush_raw  & reset;
    assign id_ex_flush  = id_ex_flush_raw  & reset;
    assign ex_mem_flush = ex_mem_flush_raw & reset;
    assign md_start     = md_start_raw     & reset;
    assign md_error     = md_error_q;
    assign stall_count  = stall_count_q;

endmodule
